// File: rtl/usermem_io_pkg.sv
// Shared constants for the user-memory responder: I/O register map, CTRL bit
// positions, the timer write-request bundle and the IRQ FSM state encoding.
package usermem_io_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'hF0;
  localparam logic [7:0] ADDR_RELOAD = 8'hF1;
  localparam logic [7:0] ADDR_COUNT  = 8'hF2;
  localparam logic [7:0] ADDR_STATUS = 8'hF3;
  localparam logic [7:0] ADDR_SWIRQ  = 8'hF4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AR     = 1;
  localparam int CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } irq_state_e;

  // One CPU write decoded into per-register strobes for the timer.
  typedef struct packed {
    logic       ctrl_we;
    logic       reload_we;
    logic       count_we;
    logic       status_we;
    logic [7:0] wdata;
  } tmr_wr_t;

endpackage

// File: rtl/usermem_io_timer.sv
// Memory-mapped down-counter: prescaler, COUNT/RELOAD/CTRL registers and the
// sticky expired flag. Emits a one-cycle expiry pulse on the clock it expires.
module io_timer
  import usermem_io_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  tmr_wr_t    wr_i,
  output logic [2:0] ctrl_o,
  output logic [7:0] reload_o,
  output logic [7:0] count_o,
  output logic       expired_o,
  output logic       expiry_o
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc_q, psc_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [7:0]    reload_q, reload_d;
  logic [7:0]    count_q, count_d;
  logic          expired_q, expired_d;
  logic          tick, tick_ok;

  assign tick     = ctrl_q[CTRL_EN] && (psc_q == PSC_LAST);
  // A CPU write to COUNT or CTRL owns the cycle; the colliding tick is lost.
  assign tick_ok  = tick && !wr_i.count_we && !wr_i.ctrl_we;
  assign expiry_o = tick_ok && (count_q == 8'd0);

  always_comb begin
    psc_d     = '0;
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    expired_d = expired_q;

    if (ctrl_q[CTRL_EN] && (psc_q != PSC_LAST)) psc_d = psc_q + 1'b1;

    if (tick_ok) begin
      if (count_q != 8'd0)      count_d = count_q - 8'd1;
      else if (ctrl_q[CTRL_AR]) count_d = reload_q;
      else                      ctrl_d[CTRL_EN] = 1'b0;
    end

    if (wr_i.ctrl_we)   ctrl_d   = wr_i.wdata[2:0];
    if (wr_i.reload_we) reload_d = wr_i.wdata;
    if (wr_i.count_we)  count_d  = wr_i.wdata;
    if (wr_i.status_we && wr_i.wdata[0]) expired_d = 1'b0;
    // A new expiry beats a clear landing in the same cycle.
    if (expiry_o) expired_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q     <= '0;
      ctrl_q    <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      psc_q     <= psc_d;
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign reload_o  = reload_q;
  assign count_o   = count_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/usermem_io.sv
// User-memory responder for the control unit: RAM in the low region, a timer
// and interrupt source in the top 16 bytes, and a rate-limited IRQ pulse FSM.
module usermem_io
  import usermem_io_pkg::*;
#(
  parameter int RAM_DEPTH = 240,
  parameter int PRESCALE  = 4,
  parameter int IRQ_GAP   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] usermem_address,
  input  logic [7:0] usermem_data_out,
  input  logic       rw,
  output logic [7:0] usermem_data_in,
  output logic       interrupt
);

  localparam logic [8:0] RAM_TOP  = 9'(RAM_DEPTH);
  localparam logic [7:0] GAP_LAST = 8'(IRQ_GAP - 1);

  logic [7:0] mem [0:RAM_DEPTH-1];
  logic       is_ram, swirq_we;
  tmr_wr_t    tw;
  logic [2:0] ctrl;
  logic [7:0] reload, count;
  logic       expired, expiry, irq_event;

  irq_state_e state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic       pending_q, pending_d;
  logic       irq_q;

  assign is_ram       = {1'b0, usermem_address} < RAM_TOP;
  assign tw.ctrl_we   = rw && (usermem_address == ADDR_CTRL);
  assign tw.reload_we = rw && (usermem_address == ADDR_RELOAD);
  assign tw.count_we  = rw && (usermem_address == ADDR_COUNT);
  assign tw.status_we = rw && (usermem_address == ADDR_STATUS);
  assign tw.wdata     = usermem_data_out;
  assign swirq_we     = rw && (usermem_address == ADDR_SWIRQ);

  always_ff @(posedge clk) begin
    if (rw && is_ram) mem[usermem_address] <= usermem_data_out;
  end

  always_comb begin
    usermem_data_in = 8'h00;
    if (is_ram) usermem_data_in = mem[usermem_address];
    else begin
      case (usermem_address)
        ADDR_CTRL:   usermem_data_in = {5'b0, ctrl};
        ADDR_RELOAD: usermem_data_in = reload;
        ADDR_COUNT:  usermem_data_in = count;
        ADDR_STATUS: usermem_data_in = {7'b0, expired};
        default:     usermem_data_in = 8'h00;
      endcase
    end
  end

  io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .wr_i      (tw),
    .ctrl_o    (ctrl),
    .reload_o  (reload),
    .count_o   (count),
    .expired_o (expired),
    .expiry_o  (expiry)
  );

  assign irq_event = (expiry && ctrl[CTRL_IRQ_EN]) || swirq_we;

  // Pending absorbs events that land during PULSE/GAP so none are lost; the
  // last GAP cycle may hand straight to PULSE, giving IRQ_GAP idle clocks.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pending_d = pending_q || irq_event;
    case (state_q)
      S_IDLE: begin
        if (pending_d) begin
          state_d   = S_PULSE;
          pending_d = 1'b0;
        end
      end
      S_PULSE: begin
        state_d = S_GAP;
        gap_d   = 8'd0;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (pending_d) begin
            state_d   = S_PULSE;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gap_q     <= 8'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      irq_q     <= (state_d == S_PULSE);
    end
  end

  assign interrupt = irq_q;

endmodule
